// File: rtl/snake_pkg.sv
// Shared constants, heading/state encodings and heading selection for the snake game logic.
package snake_pkg;

    localparam int COORD_W               = 7;
    localparam int GRID_W                = 124;
    localparam int GRID_H                = 81;
    localparam int START_X               = 62;
    localparam int START_Y               = 40;
    localparam int SNAKE_MAX_DEFAULT     = 16;
    localparam int SNAKE_LEN_BIT_DEFAULT = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [3:0] {
        HEAD_UP    = 4'b1000,
        HEAD_DOWN  = 4'b0100,
        HEAD_LEFT  = 4'b0010,
        HEAD_RIGHT = 4'b0001
    } heading_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2,
        DEAD  = 2'd3
    } state_t;

    function automatic heading_t opposite(input heading_t h);
        heading_t o;
        case (h)
            HEAD_UP:    o = HEAD_DOWN;
            HEAD_DOWN:  o = HEAD_UP;
            HEAD_LEFT:  o = HEAD_RIGHT;
            default:    o = HEAD_LEFT;
        endcase
        return o;
    endfunction

    // Priority up > down > right > left; a reversal request keeps the current heading.
    function automatic heading_t select_heading(input heading_t current, input logic req_up,
                                                input logic req_down, input logic req_left,
                                                input logic req_right);
        heading_t req;
        if (req_up)         req = HEAD_UP;
        else if (req_down)  req = HEAD_DOWN;
        else if (req_right) req = HEAD_RIGHT;
        else if (req_left)  req = HEAD_LEFT;
        else                req = current;
        return (req == opposite(current)) ? current : req;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculation with wall detection.
// Defining SNAKE_WRAP_EN makes the head wrap around the grid edges instead of hitting a wall.
module snake_next_head
    import snake_pkg::*;
(
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  heading_t           heading,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               wall_hit
);

    localparam coord_t X_LAST = coord_t'(GRID_W - 1);
    localparam coord_t Y_LAST = coord_t'(GRID_H - 1);

    // Edge tests happen before any arithmetic so 7-bit wrap never masks a wall.
    always_comb begin
        next_x   = head_x;
        next_y   = head_y;
        wall_hit = 1'b0;
        case (heading)
            HEAD_UP: begin
                if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_y = Y_LAST;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_y = head_y - 1'b1;
                end
            end
            HEAD_DOWN: begin
                if (head_y == Y_LAST) begin
`ifdef SNAKE_WRAP_EN
                    next_y = '0;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_y = head_y + 1'b1;
                end
            end
            HEAD_LEFT: begin
                if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
                    next_x = X_LAST;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_x = head_x - 1'b1;
                end
            end
            default: begin
                if (head_x == X_LAST) begin
`ifdef SNAKE_WRAP_EN
                    next_x = '0;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    next_x = head_x + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement, growth and collision engine that streams body segments to the renderer.
// Optional build macro SNAKE_WRAP_EN (see snake_next_head) turns walls into wrap-around edges.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int SNAKE_LENGTH_BIT = SNAKE_LEN_BIT_DEFAULT,
    parameter int SNAKE_LENGTH_MAX = SNAKE_MAX_DEFAULT
)(
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_tick,
    input  logic                        up,
    input  logic                        down,
    input  logic                        left,
    input  logic                        right,
    input  logic [COORD_W-1:0]          fruit_x,
    input  logic [COORD_W-1:0]          fruit_y,
    output logic [COORD_W-1:0]          snake_head_x,
    output logic [COORD_W-1:0]          snake_head_y,
    output logic [COORD_W-1:0]          snake_body_x,
    output logic [COORD_W-1:0]          snake_body_y,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        dir_up,
    output logic                        dir_down,
    output logic                        dir_left,
    output logic                        dir_right,
    output logic                        fruit_eaten,
    output logic                        game_over,
    output logic                        busy
);

    // Length saturates at MAX, or at the largest value the length field can hold if smaller.
    localparam int LEN_SAT_I = (SNAKE_LENGTH_MAX < (1 << SNAKE_LENGTH_BIT) - 1) ?
                               SNAKE_LENGTH_MAX : (1 << SNAKE_LENGTH_BIT) - 1;
    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_SAT     = SNAKE_LENGTH_BIT'(LEN_SAT_I);
    localparam logic [SNAKE_LENGTH_BIT-1:0] STREAM_LAST = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_RESET   = SNAKE_LENGTH_BIT'(2);

    state_t                      state;
    state_t                      state_next;
    heading_t                    heading;
    heading_t                    heading_req;
    coord_t                      body_x [SNAKE_LENGTH_MAX];
    coord_t                      body_y [SNAKE_LENGTH_MAX];
    coord_t                      next_x;
    coord_t                      next_y;
    logic                        wall_hit;
    logic [SNAKE_LENGTH_BIT-1:0] scan_idx;
    logic [SNAKE_LENGTH_BIT-1:0] stream_idx;
    logic                        latch_heading;
    logic                        commit_move;
    logic                        self_hit;
    logic                        scan_last;
    logic                        fruit_hit;

    snake_next_head u_next_head (
        .head_x   (snake_head_x),
        .head_y   (snake_head_y),
        .heading  (heading),
        .next_x   (next_x),
        .next_y   (next_y),
        .wall_hit (wall_hit)
    );

    assign heading_req = select_heading(heading, up, down, left, right);
    assign self_hit    = (snake_head_x == body_x[scan_idx]) && (snake_head_y == body_y[scan_idx]);
    assign scan_last   = (scan_idx == snake_length - 1'b1);
    assign fruit_hit   = (next_x == fruit_x) && (next_y == fruit_y);

    assign dir_up    = heading[3];
    assign dir_down  = heading[2];
    assign dir_left  = heading[1];
    assign dir_right = heading[0];
    assign game_over = (state == DEAD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock_25) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        latch_heading = 1'b0;
        commit_move   = 1'b0;
        case (state)
            IDLE: begin
                if (move_tick) begin
                    latch_heading = 1'b1;
                    state_next    = MOVE;
                end
            end
            MOVE: begin
                if (wall_hit) begin
                    state_next = DEAD;
                end else begin
                    commit_move = 1'b1;
                    state_next  = CHECK;
                end
            end
            CHECK: begin
                if (self_hit)       state_next = DEAD;
                else if (scan_last) state_next = IDLE;
            end
            default: state_next = DEAD;
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            snake_head_x <= coord_t'(START_X);
            snake_head_y <= coord_t'(START_Y);
            for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                body_x[i] <= '0;
                body_y[i] <= '0;
            end
            body_x[0]    <= coord_t'(START_X - 1);
            body_y[0]    <= coord_t'(START_Y);
            body_x[1]    <= coord_t'(START_X - 2);
            body_y[1]    <= coord_t'(START_Y);
            snake_length <= LEN_RESET;
            heading      <= HEAD_RIGHT;
            fruit_eaten  <= 1'b0;
            scan_idx     <= '0;
        end else begin
            fruit_eaten <= 1'b0;
            if (latch_heading) heading <= heading_req;
            if (commit_move) begin
                for (int i = 1; i < SNAKE_LENGTH_MAX; i++) begin
                    body_x[i] <= body_x[i-1];
                    body_y[i] <= body_y[i-1];
                end
                body_x[0]    <= snake_head_x;
                body_y[0]    <= snake_head_y;
                snake_head_x <= next_x;
                snake_head_y <= next_y;
                if (fruit_hit) begin
                    fruit_eaten <= 1'b1;
                    if (snake_length != LEN_SAT) snake_length <= snake_length + 1'b1;
                end
            end
            scan_idx <= (state == CHECK) ? scan_idx + 1'b1 : '0;
        end
    end

    // Free-running segment stream; index and data leave together.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            stream_idx   <= '0;
            body_count   <= '0;
            snake_body_x <= '0;
            snake_body_y <= '0;
        end else begin
            body_count   <= stream_idx;
            snake_body_x <= body_x[stream_idx];
            snake_body_y <= body_y[stream_idx];
            stream_idx   <= (stream_idx == STREAM_LAST) ? '0 : stream_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: a behavioural snake model feeds a scoreboard queue.
`timescale 1ns/1ps
module tb_snake_body_engine;
    import snake_pkg::*;

    localparam int MAX = 16;

    logic       clock_25 = 1'b0;
    logic       reset, move_tick, up, down, left, right;
    logic [6:0] fruit_x, fruit_y;
    logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
    logic [3:0] body_count, snake_length;
    logic       dir_up, dir_down, dir_left, dir_right;
    logic       fruit_eaten, game_over, busy;

    snake_body_engine dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .move_tick    (move_tick),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .fruit_x      (fruit_x),
        .fruit_y      (fruit_y),
        .snake_head_x (snake_head_x),
        .snake_head_y (snake_head_y),
        .snake_body_x (snake_body_x),
        .snake_body_y (snake_body_y),
        .body_count   (body_count),
        .snake_length (snake_length),
        .dir_up       (dir_up),
        .dir_down     (dir_down),
        .dir_left     (dir_left),
        .dir_right    (dir_right),
        .fruit_eaten  (fruit_eaten),
        .game_over    (game_over),
        .busy         (busy)
    );

    always #20 clock_25 = ~clock_25;

    typedef struct {
        int hx;
        int hy;
        int len;
        int eaten;
        int dir;
        int dead;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;
    int   last_dead = 0;

    // Reference snake; heading one-hot as {up,down,left,right}.
    int m_hx, m_hy, m_len, m_dir, m_dead;
    int m_bx[MAX];
    int m_by[MAX];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        if (observed !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int dirOnehot();
        return {28'd0, dir_up, dir_down, dir_left, dir_right};
    endfunction

    task automatic modelReset();
        m_hx = 62; m_hy = 40; m_len = 2; m_dir = 1; m_dead = 0;
        for (int i = 0; i < MAX; i++) begin
            m_bx[i] = 0;
            m_by[i] = 0;
        end
        m_bx[0] = 61; m_by[0] = 40;
        m_bx[1] = 60; m_by[1] = 40;
    endtask

    task automatic modelMove(input logic u, input logic d, input logic l, input logic r,
                             output exp_t e);
        int  req, nx, ny;
        bit  wall;
        e.eaten = 0;
        if (m_dead == 0) begin
            req = u ? 8 : d ? 4 : r ? 1 : l ? 2 : m_dir;
            if (!((req == 8 && m_dir == 4) || (req == 4 && m_dir == 8) ||
                  (req == 2 && m_dir == 1) || (req == 1 && m_dir == 2)))
                m_dir = req;
            nx = m_hx; ny = m_hy;
            case (m_dir)
                8:       ny = ny - 1;
                4:       ny = ny + 1;
                2:       nx = nx - 1;
                default: nx = nx + 1;
            endcase
            wall = 0;
            if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
`ifdef SNAKE_WRAP_EN
                nx = (nx + GRID_W) % GRID_W;
                ny = (ny + GRID_H) % GRID_H;
`else
                wall = 1;
`endif
            end
            if (wall) begin
                m_dead = 1;
            end else begin
                if (nx == int'(fruit_x) && ny == int'(fruit_y)) begin
                    e.eaten = 1;
                    if (m_len < 15) m_len++;
                end
                for (int i = MAX - 1; i > 0; i--) begin
                    m_bx[i] = m_bx[i-1];
                    m_by[i] = m_by[i-1];
                end
                m_bx[0] = m_hx; m_by[0] = m_hy;
                m_hx = nx; m_hy = ny;
                for (int k = 0; k < m_len; k++)
                    if (m_bx[k] == m_hx && m_by[k] == m_hy) m_dead = 1;
            end
        end
        e.hx = m_hx; e.hy = m_hy; e.len = m_len; e.dir = m_dir; e.dead = m_dead;
    endtask

    // Called at a falling edge; the tick is sampled on the next rising edge.
    task automatic applyStimulus(input logic u, input logic d, input logic l, input logic r);
        exp_t e;
        up = u; down = d; left = l; right = r;
        move_tick = 1'b1;
        modelMove(u, d, l, r, e);
        sb.push_back(e);
        @(posedge clock_25);
        @(negedge clock_25);
        move_tick = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    task automatic observeT2();
        exp_t e;
        @(posedge clock_25);
        @(negedge clock_25);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            checkOutput("head_x", snake_head_x, e.hx);
            checkOutput("head_y", snake_head_y, e.hy);
            checkOutput("length", snake_length, e.len);
            checkOutput("fruit_eaten", fruit_eaten, e.eaten);
            checkOutput("heading", dirOnehot(), e.dir);
            last_dead = e.dead;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && !game_over && n < 60) begin
            @(negedge clock_25);
            n++;
        end
        if (n >= 60) checkOutput("idle_timeout", 0, 1);
        checkOutput("game_over", game_over, last_dead);
    endtask

    task automatic doMove(input logic u, input logic d, input logic l, input logic r);
        applyStimulus(u, d, l, r);
        observeT2();
        waitIdle();
    endtask

    task automatic checkStream();
        for (int i = 0; i < m_len; i++) begin
            int n = 0;
            while (int'(body_count) != i && n < 40) begin
                @(negedge clock_25);
                n++;
            end
            if (n >= 40) checkOutput("stream_timeout", 0, 1);
            checkOutput($sformatf("body%0d_x", i), snake_body_x, m_bx[i]);
            checkOutput($sformatf("body%0d_y", i), snake_body_y, m_by[i]);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        move_tick = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        @(posedge clock_25);
        @(posedge clock_25);
        @(negedge clock_25);
        reset = 1'b0;
        modelReset();
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; move_tick = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        fruit_x = 7'd0; fruit_y = 7'd0;
        doReset();

        checkOutput("rst_head_x", snake_head_x, 62);
        checkOutput("rst_head_y", snake_head_y, 40);
        checkOutput("rst_length", snake_length, 2);
        checkOutput("rst_heading", dirOnehot(), 1);
        checkOutput("rst_body_count", body_count, 0);
        checkOutput("rst_body_x", snake_body_x, 0);
        checkOutput("rst_fruit_eaten", fruit_eaten, 0);
        checkOutput("rst_game_over", game_over, 0);
        checkOutput("rst_busy", busy, 0);

        doMove(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_head_x", snake_head_x, 63);
        checkStream();

        doMove(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("reverse_head_x", snake_head_x, 64);
        checkOutput("reverse_dir_right", dir_right, 1);

        fruit_x = 7'd63; fruit_y = 7'd40;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        observeT2();
        @(negedge clock_25);
        checkOutput("eaten_one_cycle", fruit_eaten, 0);
        waitIdle();
        checkOutput("grow_length", snake_length, 3);
        checkStream();

        fruit_x = 7'd64;
        doMove(1'b0, 1'b0, 1'b0, 1'b0);
        fruit_x = 7'd65;
        doMove(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("grow5_length", snake_length, 5);
        fruit_x = 7'd0; fruit_y = 7'd0;
        doMove(1'b0, 1'b1, 1'b0, 1'b0);
        doMove(1'b0, 1'b0, 1'b1, 1'b0);
        doMove(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tail_hit_game_over", game_over, 1);
        doMove(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("dead_head_x", snake_head_x, 64);
        checkOutput("dead_head_y", snake_head_y, 40);

        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        observeT2();
        move_tick = 1'b1; down = 1'b1;
        @(posedge clock_25);
        @(negedge clock_25);
        move_tick = 1'b0; down = 1'b0;
        waitIdle();
        repeat (20) @(negedge clock_25);
        checkOutput("drop_head_x", snake_head_x, m_hx);
        checkOutput("drop_head_y", snake_head_y, m_hy);
        checkOutput("drop_busy", busy, 0);

        fruit_x = 7'd63; fruit_y = 7'd40;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock_25);
        @(negedge clock_25);
        checkOutput("check_busy", busy, 1);
        checkOutput("check_eaten", fruit_eaten, 1);
        reset = 1'b1;
        @(posedge clock_25);
        @(negedge clock_25);
        reset = 1'b0;
        checkOutput("midrst_head_x", snake_head_x, 62);
        checkOutput("midrst_head_y", snake_head_y, 40);
        checkOutput("midrst_length", snake_length, 2);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_eaten", fruit_eaten, 0);
        checkOutput("midrst_game_over", game_over, 0);
        checkOutput("midrst_heading", dirOnehot(), 1);
        checkOutput("midrst_body_count", body_count, 0);
        sb.delete();
        modelReset();

        fruit_x = 7'd0; fruit_y = 7'd0;
        doReset();
        for (int i = 0; i < 61; i++) doMove(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("edge_head_x", snake_head_x, 123);
        doMove(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SNAKE_WRAP_EN
        checkOutput("wrap_head_x", snake_head_x, 0);
        checkOutput("wrap_game_over", game_over, 0);
`else
        checkOutput("wall_head_x", snake_head_x, 123);
        checkOutput("wall_game_over", game_over, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Game-logic stage directly upstream of the game renderer. On each move tick it advances the snake one grid block in the current heading, grows it when the head lands on the fruit, and detects wall and self collisions. It continuously streams every body segment as an indexed (`body_count`, x, y) pair so the renderer can rebuild its body matrix. It also drives the head coordinates, the heading one-hot, `snake_length`, `fruit_eaten` and `game_over`.

## Interface
- `SNAKE_LENGTH_BIT`, 4: width of the length and index fields.
- `SNAKE_LENGTH_MAX`, 16: number of body entries (excludes the head).
- `GRID_W`, 124: grid columns, x in 0..GRID_W-1.
- `GRID_H`, 81: grid rows, y in 0..GRID_H-1.
- `START_X`, 62; `START_Y`, 40: head position at reset.
- `clock_25`  in  1  25 MHz pixel clock; single clock domain.
- `reset`  in  1  reset, synchronous and active-high.
- `move_tick`  in  1  one-cycle pulse requesting one move step.
- `up`, `down`, `left`, `right`  in  1 each  requested direction from the controller.
- `fruit_x`, `fruit_y`  in  7 each  fruit block coordinates.
- `snake_head_x`, `snake_head_y`  out  7 each  head block coordinates.
- `snake_body_x`, `snake_body_y`  out  7 each  streamed segment coordinates.
- `body_count`  out  SNAKE_LENGTH_BIT  index of the streamed segment.
- `snake_length`  out  SNAKE_LENGTH_BIT  non-head segment count; the tail is index `snake_length-1`.
- `dir_up`, `dir_down`, `dir_left`, `dir_right`  out  1 each  current heading, one-hot.
- `fruit_eaten`  out  1  one-cycle pulse on growth.
- `game_over`  out  1  sticky collision flag.
- `busy`  out  1  high when not IDLE.

## Operation
- Body array `body[0..MAX-1]`:
  - `body[0]` sits directly behind the head.
  - Entries at index ≥ `snake_length` are don't-care but are still streamed.
- FSM states: IDLE, MOVE, CHECK, DEAD.
- IDLE, on `move_tick`:
  - Latch the new heading. Input priority is up > down > right > left.
  - A request for the direction opposite the current heading is ignored.
  - No input asserted: keep the current heading.
  - Then go to MOVE.
- MOVE, one cycle:
  - `body[i] <= body[i-1]` for i = 1..MAX-1; `body[0] <=` old head; head <= next head.
  - If next head == (`fruit_x`, `fruit_y`): `snake_length` increments, saturating at MAX, and `fruit_eaten` pulses. The pulse fires even when saturated.
  - Wall exit: next state DEAD; head and body are not updated.
- CHECK:
  - Scan index k = 0..`snake_length`-1, one compare per cycle, new head against `body[k]`.
  - Match: go to DEAD. Scan complete with no match: go to IDLE.
- DEAD: `game_over` = 1 and held. All ticks are ignored. Only `reset` exits.
- Stream:
  - A free-running counter p runs 0..MAX-1 and wraps, in every state.
  - `body_count <= p`, `snake_body_x/y <= body[p]`, registered together in the same cycle.
- Reset values:
  - Head = (START_X, START_Y).
  - `body[0]` = (START_X-1, START_Y), `body[1]` = (START_X-2, START_Y); all other entries 0.
  - `snake_length` = 2; heading right (`dir_right` = 1, others 0).
  - `body_count`, `snake_body_x/y`, `fruit_eaten`, `game_over`, `busy` all 0; state IDLE.
- Coordinate arithmetic is 7-bit unsigned. Compute decrement underflow and increment overflow against the bounds before wrapping.

## Timing
- Tick sampled at T0; MOVE occurs at T1.
- At T2:
  - New head and body are visible.
  - `fruit_eaten` is high for exactly cycle T2.
  - `snake_length` is updated.
- CHECK takes `snake_length` cycles. `busy` is high from T1 until the cycle IDLE is re-entered.
- A `move_tick` while `busy` = 1 is dropped, not queued.
- Stream latency: `body_count` and data are aligned in the same cycle. A full refresh takes ≤ MAX cycles after any MOVE.
- `reset` mid-operation: everything returns to reset values on the next edge, from any state.
- Tick and reset in the same cycle: reset wins.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - The head wraps at grid edges: x -1 → GRID_W-1, x GRID_W → 0, same for y.
  - Walls are never fatal.
- `SNAKE_WRAP_EN` undefined: leaving the grid enters DEAD.

## Structure
- Package `snake_pkg` holds:
  - Grid dimensions, start coordinates and the default MAX.
  - Heading encoding and FSM state encoding.
- Sub-module `snake_next_head`, combinational:
  - Inputs: head and heading.
  - Outputs: next head and a wall-hit flag.
  - Contains the wrap logic under `SNAKE_WRAP_EN`.

## Test plan
- Reset, then one tick with no direction input:
  - Head (63,40), `body[0]` = (62,40), `body[1]` = (61,40), length 2.
  - `body_count` 0 and 1 stream those values.
- Heading right, then assert `left` with a tick: heading stays right and the head moves to x+1.
- Fruit at (63,40), tick from reset:
  - `fruit_eaten` is a single pulse at T2; length 3; tail `body[2]` = (60,40).
- Tail collision:
  - Grow to length 5, then steer down, left, up.
  - The head lands on `body[k]`; `game_over` rises after the CHECK scan, and later ticks are ignored.
- Head at x = 123 heading right, tick:
  - Without the macro: `game_over` = 1 and the head stays at 123.
  - With `SNAKE_WRAP_EN`: head x = 0.
- Tick while `busy` = 1 is dropped. Reset asserted in CHECK returns all outputs to reset values on the next cycle.
